// File: rtl/dmm_pkg.sv
// Shared encodings for the memory-manager requester: ops, response codes,
// FSM states and the packed command word carried through the FIFO.
package dmm_pkg;

  // Command opcodes as presented on cmd_op.
  localparam logic OP_MALLOC = 1'b0;
  localparam logic OP_FREE   = 1'b1;

  // Response codes; 2'b11 is reserved and never produced.
  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_REJECT  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  localparam int CMD_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  // Layout of one FIFO entry: {op, size, register id}.
  typedef struct packed {
    logic       op;
    logic [5:0] size;
    logic [2:0] regid;
  } cmd_t;

endpackage

// File: rtl/dmm_cmd_fifo.sv
// Small command FIFO with a combinational head. DEPTH must be a power of 2
// and at least 2 so the pointers wrap naturally.
module dmm_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dmm_requester.sv
// Host-side requester for a malloc/free memory manager: queues commands,
// screens them against an allocation bitmap, strobes the manager, waits for
// the matching ack (with timeout) and returns a status to the host.
module dmm_requester
  import dmm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int GAP        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [5:0] cmd_size,
  input  logic [2:0] cmd_reg,
  output logic       malloc,
  output logic       free,
  output logic [5:0] requestedmemsize,
  output logic [2:0] regmips,
  input  logic       mack,
  input  logic       frack,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status,
  output logic [2:0] rsp_reg,
  output logic       busy
);

  // Counter value seen in the final permitted WAIT cycle / final GAP cycle.
  localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT - 1);
  localparam logic [6:0] GAP_LAST     = 7'(GAP - 1);

  state_t           state_reg, state_next;
  cmd_t             cur_cmd_reg;
  logic [1:0]       status_reg, status_next;
  logic [6:0]       cnt_reg, cnt_next;
  logic [7:0]       alloc_map_reg, alloc_map_next;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             ack_match;
  logic             ack_ok;
  logic             reject;
  logic             payload_on;

  dmm_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_size, cmd_reg}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  // Only the ack that belongs to the outstanding op counts.
  assign ack_match = (cur_cmd_reg.op == OP_MALLOC) ? mack : frack;

  // Screen: double malloc, zero-size malloc, or free of an unallocated reg.
  assign reject = (cur_cmd_reg.op == OP_MALLOC)
                ? (alloc_map_reg[cur_cmd_reg.regid] || (cur_cmd_reg.size == 6'd0))
                : !alloc_map_reg[cur_cmd_reg.regid];

  // Per-register bitmap update on an accepted ack.
  for (genvar gi = 0; gi < 8; gi++) begin : g_map
    assign alloc_map_next[gi] = (ack_ok && (cur_cmd_reg.regid == 3'(gi)))
                              ? (cur_cmd_reg.op == OP_MALLOC)
                              : alloc_map_reg[gi];
  end

  // Next-state, counter, status and FIFO pop decisions.
  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    cnt_next    = cnt_reg;
    fifo_pop    = 1'b0;
    ack_ok      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          status_next = RSP_REJECT;
          state_next  = ST_RESP;
        end else begin
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + 7'd1;
        // A matching ack in the last permitted cycle still wins.
        if (ack_match) begin
          ack_ok      = 1'b1;
          status_next = RSP_OK;
          state_next  = ST_RESP;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          status_next = RSP_TIMEOUT;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_next   = '0;
          state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_next = cnt_reg + 7'd1;
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, working command, status, counter and bitmap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cur_cmd_reg   <= '0;
      status_reg    <= RSP_OK;
      cnt_reg       <= '0;
      alloc_map_reg <= '0;
    end else begin
      state_reg     <= state_next;
      status_reg    <= status_next;
      cnt_reg       <= cnt_next;
      alloc_map_reg <= alloc_map_next;
      if (fifo_pop) begin
        cur_cmd_reg <= cmd_t'(fifo_head);
      end
    end
  end

  // Strobes last exactly the single ISSUE cycle; payload is held from ISSUE
  // through the ack (or timeout) cycle and is zero elsewhere.
  assign payload_on       = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign malloc           = (state_reg == ST_ISSUE) && (cur_cmd_reg.op == OP_MALLOC);
  assign free             = (state_reg == ST_ISSUE) && (cur_cmd_reg.op == OP_FREE);
  assign requestedmemsize = payload_on ? cur_cmd_reg.size  : 6'd0;
  assign regmips          = payload_on ? cur_cmd_reg.regid : 3'd0;

  assign rsp_valid  = (state_reg == ST_RESP);
  assign rsp_status = rsp_valid ? status_reg : 2'b00;
  assign rsp_reg    = rsp_valid ? cur_cmd_reg.regid : 3'd0;

  assign busy = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dmm_requester.sv
// Self-checking bench for dmm_requester: a command table plus hand-written
// sequences for latency, backpressure, FIFO-full and reset corners.
`timescale 1ns/1ps
module tb_dmm_requester;
  import dmm_pkg::*;

  localparam int ACK_MATCH = 0;  // matching ack after ack_delay cycles
  localparam int ACK_NONE  = 1;  // no ack at all
  localparam int ACK_WRONG = 2;  // only the opposite ack
  localparam int ACK_LATE  = 3;  // matching ack, payload not checked

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [5:0] cmd_size;
  logic [2:0] cmd_reg;
  logic       malloc, free;
  logic [5:0] requestedmemsize;
  logic [2:0] regmips;
  logic       mack, frack;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_status;
  logic [2:0] rsp_reg;
  logic       busy;

  dmm_requester #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (64),
    .GAP        (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_size         (cmd_size),
    .cmd_reg          (cmd_reg),
    .malloc           (malloc),
    .free             (free),
    .requestedmemsize (requestedmemsize),
    .regmips          (regmips),
    .mack             (mack),
    .frack            (frack),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_status       (rsp_status),
    .rsp_reg          (rsp_reg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [5:0] size;
    logic [2:0] regid;
    int         ack_kind;
    int         ack_delay;
    logic [1:0] exp_status;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic       op;
    logic [5:0] size;
    logic [2:0] regid;
    int         ack_kind;
    int         ack_delay;
  } strobe_t;

  typedef struct {
    logic [1:0] status;
    logic [2:0] regid;
  } rsp_t;

  rsp_t    exp_q[$];
  strobe_t stb_q[$];
  int      strobe_cyc_q[$];
  int      n_checks = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      strobe_count = 0;
  int      last_strobe_cyc = 0;
  int      last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one command, wait (bounded) for cmd_ready, and record expectations.
  task automatic push_cmd(input logic op, input logic [5:0] size, input logic [2:0] regid,
                          input int ack_kind, input int ack_delay, input logic [1:0] exp_status);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_size  = size;
    cmd_reg   = regid;
    while (!cmd_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) check("push_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back('{exp_status, regid});
    if (exp_status != RSP_REJECT) stb_q.push_back('{op, size, regid, ack_kind, ack_delay});
    $display("push op=%0d size=%0d reg=%0d expect status=%0d", op, size, regid, exp_status);
  endtask

  // Wait until every expected response is seen and the DUT is idle.
  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check(name, 32'(guard < 400), 1);
  endtask

  // Manager model: checks each strobe against the queue and answers it.
  initial begin : responder
    strobe_t s;
    mack  = 1'b0;
    frack = 1'b0;
    forever begin
      @(negedge clk);
      if (malloc || free) begin
        strobe_count++;
        last_strobe_cyc = cyc;
        strobe_cyc_q.push_back(cyc);
        check("strobe_expected", 32'(stb_q.size() != 0), 1);
        if (stb_q.size() != 0) begin
          s = stb_q.pop_front();
          check("strobe_malloc", malloc, s.op == OP_MALLOC);
          check("strobe_free", free, s.op == OP_FREE);
          check("strobe_size", requestedmemsize, s.size);
          check("strobe_reg", regmips, s.regid);
          @(posedge clk); #1;
          check("strobe_width", malloc | free, 0);
          if (s.ack_kind != ACK_NONE) begin
            repeat (s.ack_delay - 1) begin
              @(posedge clk); #1;
            end
            if (s.ack_kind == ACK_MATCH && s.ack_delay <= 64) begin
              check("payload_held_size", requestedmemsize, s.size);
              check("payload_held_reg", regmips, s.regid);
            end
            if ((s.ack_kind == ACK_WRONG) ^ (s.op == OP_MALLOC)) mack = 1'b1;
            else frack = 1'b1;
            @(posedge clk); #1;
            mack  = 1'b0;
            frack = 1'b0;
          end
        end
      end
    end
  end

  // Response scoreboard: pops one expectation per completed handshake.
  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        last_rsp_cyc = cyc;
        check("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_status", rsp_status, e.status);
          check("rsp_reg", rsp_reg, e.regid);
          $display("rsp status=%0d reg=%0d (expected %0d/%0d)", rsp_status, rsp_reg, e.status, e.regid);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  vec_t vecs[10];

  initial begin : main
    int rv_seen;
    vecs[0] = '{OP_MALLOC, 6'd12, 3'd3, ACK_MATCH, 2,  RSP_OK,      3};
    vecs[1] = '{OP_MALLOC, 6'd8,  3'd3, ACK_MATCH, 1,  RSP_REJECT,  -1};
    vecs[2] = '{OP_FREE,   6'd0,  3'd5, ACK_MATCH, 1,  RSP_REJECT,  -1};
    vecs[3] = '{OP_MALLOC, 6'd0,  3'd5, ACK_MATCH, 1,  RSP_REJECT,  -1};
    vecs[4] = '{OP_FREE,   6'd0,  3'd3, ACK_NONE,  0,  RSP_TIMEOUT, 65};
    vecs[5] = '{OP_MALLOC, 6'd63, 3'd7, ACK_MATCH, 64, RSP_OK,      65};
    vecs[6] = '{OP_MALLOC, 6'd1,  3'd0, ACK_MATCH, 65, RSP_TIMEOUT, 65};
    vecs[7] = '{OP_FREE,   6'd0,  3'd7, ACK_WRONG, 1,  RSP_TIMEOUT, 65};
    vecs[8] = '{OP_FREE,   6'd0,  3'd3, ACK_MATCH, 1,  RSP_OK,      2};
    vecs[9] = '{OP_MALLOC, 6'd33, 3'd0, ACK_MATCH, 5,  RSP_OK,      6};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_size  = '0;
    cmd_reg   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_malloc", malloc, 0);
    check("rst_free", free, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_size", requestedmemsize, 0);
    check("rst_regmips", regmips, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_reg", rsp_reg, 0);
    check("rst_bitmap", dut.alloc_map_reg, 0);
    check("rst_counter", dut.cnt_reg, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table of single transactions, each run to completion.
    for (int i = 0; i < 10; i++) begin
      push_cmd(vecs[i].op, vecs[i].size, vecs[i].regid, vecs[i].ack_kind,
               vecs[i].ack_delay, vecs[i].exp_status);
      wait_drain("table_drain");
      if (vecs[i].exp_lat >= 0) check("strobe_to_rsp_latency", last_rsp_cyc - last_strobe_cyc, vecs[i].exp_lat);
      check("idle_size_zero", requestedmemsize, 0);
      check("idle_regmips_zero", regmips, 0);
    end
    check("table_bitmap", dut.alloc_map_reg, 8'h81);
    check("table_strobe_count", strobe_count, 7);

    // Strobe latency from accept into an empty FIFO.
    push_cmd(OP_MALLOC, 6'd4, 3'd1, ACK_MATCH, 1, RSP_OK);
    check("lat_t0_malloc", malloc, 0);
    check("lat_t0_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_t1_malloc", malloc, 0);
    @(posedge clk); #1;
    check("lat_t2_malloc", malloc, 1);
    wait_drain("lat_drain");
    check("lat_bitmap", dut.alloc_map_reg, 8'h83);

    // Response backpressure: outputs must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    push_cmd(OP_FREE, 6'd5, 3'd1, ACK_MATCH, 1, RSP_OK);
    begin
      int guard = 0;
      while (!rsp_valid && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      check("bp_rsp_arrives", 32'(guard < 50), 1);
    end
    repeat (3) begin
      check("bp_valid_held", rsp_valid, 1);
      check("bp_status_held", rsp_status, RSP_OK);
      check("bp_reg_held", rsp_reg, 1);
      check("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_bitmap", dut.alloc_map_reg, 8'h81);

    // FIFO fill: one long transaction in flight, then five more pushes.
    strobe_cyc_q.delete();
    push_cmd(OP_MALLOC, 6'd10, 3'd2, ACK_MATCH, 20, RSP_OK);
    push_cmd(OP_MALLOC, 6'd1,  3'd4, ACK_MATCH, 1,  RSP_OK);
    push_cmd(OP_MALLOC, 6'd2,  3'd5, ACK_MATCH, 1,  RSP_OK);
    push_cmd(OP_MALLOC, 6'd3,  3'd6, ACK_MATCH, 1,  RSP_OK);
    push_cmd(OP_FREE,   6'd0,  3'd4, ACK_MATCH, 1,  RSP_OK);
    check("full_cmd_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    check("full_cmd_ready_still_low", cmd_ready, 0);
    push_cmd(OP_FREE,   6'd0,  3'd2, ACK_MATCH, 1,  RSP_OK);
    wait_drain("burst_drain");
    check("burst_strobes", strobe_cyc_q.size(), 6);
    if (strobe_cyc_q.size() == 6) begin
      check("burst_spacing_0", strobe_cyc_q[1] - strobe_cyc_q[0], 26);
      for (int k = 2; k < 6; k++) check("burst_spacing", strobe_cyc_q[k] - strobe_cyc_q[k-1], 7);
    end
    check("burst_bitmap", dut.alloc_map_reg, 8'he1);

    // Reset during WAIT, ack arrives afterwards.
    push_cmd(OP_MALLOC, 6'd9, 3'd1, ACK_LATE, 6, RSP_OK);
    begin
      int guard = 0;
      while (!malloc && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      check("rst_seq_strobe_seen", 32'(guard < 20), 1);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    exp_q.delete();
    stb_q.delete();
    check("mid_rst_malloc", malloc, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_size", requestedmemsize, 0);
    check("mid_rst_regmips", regmips, 0);
    check("mid_rst_bitmap", dut.alloc_map_reg, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rv_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid || malloc || free) rv_seen = 1;
    end
    check("post_rst_no_activity", rv_seen, 0);
    check("post_rst_bitmap", dut.alloc_map_reg, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_status", rsp_status, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmm_requester.md
DMM_REQUESTER -- requirements
Module: dmm_requester

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the number of command FIFO entries (power of 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the WAIT cycles allowed before the transaction is abandoned.
REQ-003 The block SHALL have parameter GAP, default 2, the idle cycles forced between completed transactions and the next strobe.
REQ-004 The block SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports cmd_valid  in  1  and cmd_ready  out  1  forming the host command handshake.
REQ-007 The block SHALL have port cmd_op  in  1  0=malloc, 1=free.
REQ-008 The block SHALL have ports cmd_size  in  6  (bytes requested) and cmd_reg  in  3  (register id).
REQ-009 The block SHALL have ports malloc  out  1  and free  out  1  as the request strobes to the memory manager.
REQ-010 The block SHALL have ports requestedmemsize  out  6  and regmips  out  3  as the request payload.
REQ-011 The block SHALL have ports mack  in  1  and frack  in  1  as the manager acknowledges.
REQ-012 The block SHALL have ports rsp_valid  out  1  and rsp_ready  in  1  forming the host response handshake.
REQ-013 The block SHALL have ports rsp_status  out  2  and rsp_reg  out  3  carrying the result and register id.
REQ-014 The block SHALL have port busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-015 Commands SHALL be pushed on cmd_valid&cmd_ready; cmd_ready = FIFO not full; drops never occur.
REQ-016 The FSM SHALL have states IDLE, CHECK, ISSUE, WAIT, RESP, GAP; IDLE->CHECK pops the FIFO head when non-empty.
REQ-017 CHECK SHALL reject (status 01) a malloc to an allocated reg, a malloc with size 0, or a free to an unallocated reg, then go to RESP without strobing.
REQ-018 Otherwise CHECK->ISSUE; ISSUE SHALL assert exactly one of malloc/free for exactly one cycle, then go to WAIT.
REQ-019 requestedmemsize/regmips SHALL be driven from ISSUE through the ack cycle and be held stable; they SHALL be 0 otherwise.
REQ-020 WAIT SHALL accept only the matching ack (mack for malloc, frack for free); a mismatched ack is ignored; acks outside WAIT are ignored.
REQ-021 A matching ack SHALL yield status 00 and update the 8-bit allocation bitmap (set on malloc, clear on free) on the same edge.
REQ-022 A 7-bit counter SHALL clear on ISSUE entry; if it reaches TIMEOUT in WAIT without ack -> status 10, bitmap unchanged, go to RESP.
REQ-023 A matching ack in the same cycle the counter hits TIMEOUT SHALL win (status 00).
REQ-024 RESP SHALL hold rsp_valid, rsp_status, rsp_reg stable until rsp_ready, then go to GAP for GAP cycles, then IDLE.
REQ-025 Strobe latency SHALL be exactly 3 cycles: accept into an empty FIFO at edge t, FSM IDLE -> strobe high in the cycle after edge t+2.
REQ-026 FIFO push SHALL remain allowed during any FSM state; a push and pop on the same edge SHALL leave occupancy unchanged.
REQ-027 Status 11 SHALL be reserved and never produced.

Reset
REQ-028 Reset SHALL force: FSM IDLE, FIFO empty, bitmap 0, counter 0, cmd_ready 1, malloc/free/rsp_valid/busy 0, all payload outputs 0.
REQ-029 Reset mid-transaction SHALL abandon the request without a response; late acks after reset are ignored.

Structure
REQ-030 Shared package dmm_pkg SHALL hold the op encodings, rsp_status codes, and the FSM state typedef.
REQ-031 The FIFO SHALL be a sub-module dmm_cmd_fifo (width 10, depth FIFO_DEPTH); everything else SHALL be in dmm_requester.

Verification
REQ-032 Malloc reg 3 size 12, mack 2 cycles after strobe -> malloc pulse 1 cycle, rsp 00 reg 3, bitmap[3]=1.
REQ-033 Malloc reg 3 again, then free reg 5 -> both rsp 01, no strobe issued.
REQ-034 Free reg 3 with no frack, TIMEOUT=64 -> rsp 10 after 64 WAIT cycles, bitmap[3] stays 1.
REQ-035 Push 5 commands back-to-back, depth 4 -> cmd_ready low after 4th until first pop; all 5 answered in order with GAP=2 between strobes.
REQ-036 Assert reset during WAIT of malloc reg 1, then mack -> no rsp_valid, bitmap 0, outputs at reset values.
